ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction fetch stage sitting directly downstream of the PC register in the 31-instruction MIPS CPU. It consumes the current PC, issues word reads to the synchronous instruction memory, and buffers returned instructions with their PCs in a small FIFO toward decode. It drives the PC register's enable so the PC advances only when a fetch slot is available, and it flushes on control-flow redirect.

## Interface
- DEPTH, 2, FIFO entries; power of two, ≥2
- ADDR_W, 11, instruction memory word-address width
- BASE_PC, 32'h00400000, PC mapped to imem word 0 (MARS text base)
- clk  in  1  clock; all state updates on the falling edge, aligned with the PC register
- rst  in  1  reset, asynchronous, active-high
- pc_in  in  32  current PC from PC register
- pc_ena  out  1  combinational; PC register loads next PC this cycle
- redirect  in  1  branch/jump taken this cycle; upstream NPC mux already presents the target
- imem_req  out  1  combinational read strobe
- imem_addr  out  ADDR_W  combinational word address
- imem_rdata  in  32  data, valid one cycle after the request
- inst_valid  out  1  FIFO head valid
- inst_ready  in  1  decode accepts head
- inst  out  32  head instruction
- inst_pc  out  32  PC of head instruction

## Operation
- Address: imem_addr = ((pc_in − BASE_PC) >> 2) truncated to ADDR_W bits; out-of-range PCs wrap silently.
- State: FIFO (count 0..DEPTH, rd/wr pointers wrapping mod DEPTH), pending flag, pending_pc register.
- pop = inst_valid & inst_ready.
- issue = !redirect & (count + pending − pop < DEPTH); imem_req = issue; pc_ena = issue | redirect.
- On the edge ending an issue cycle: pending←1, pending_pc←pc_in. Otherwise pending←0.
- If pending at an edge (not redirect): push {imem_rdata, pending_pc} into the FIFO.
- Push and pop on the same edge: count unchanged, both pointers advance.
- redirect: FIFO emptied (count←0, pointers←0), pending←0, in-flight data discarded, no request; pc_ena=1 so the PC loads the target. The next cycle fetches the target.
- inst/inst_pc are registered FIFO head outputs; undefined content is permitted when inst_valid=0, but the bench only checks them when valid.

## Timing
- Reset: inst_valid=0, count=0, pending=0, pointers=0, inst=0, inst_pc=0; pc_ena/imem_req follow the combinational equations (issue=1 after reset).
- Latency: request in cycle N → entry visible at inst_valid in cycle N+2.
- Throughput: one instruction per cycle sustained while inst_ready=1 and DEPTH≥2.
- Full: count+pending=DEPTH with no pop → imem_req=0, pc_ena=0; the PC holds.
- rst mid-operation: all state is cleared immediately, and in-flight data is dropped.
- redirect coincident with pop: the pop is ignored because the flush takes precedence.

## Configuration
- IFETCH_ALIGN_CHECK_EN defined: adds output fetch_misalign (1 bit, reset 0). If pc_in[1:0]≠0 in a cycle where issue would be 1, the block sets fetch_misalign sticky and issues no request. While set, imem_req=0 and pc_ena=redirect. It clears on redirect or rst.
- Undefined: the port is absent, and pc_in[1:0] is ignored.

## Test plan
- Reset with pc_in=0x00400000 and inst_ready=1, with imem returning mem[i]=i+0x1000 → inst_valid first high on the 3rd edge after reset release with inst=0x1000, inst_pc=0x00400000, then 0x1001/0x00400004 on consecutive cycles.
- inst_ready=0 for 5 cycles → count=2, imem_req=0, pc_ena=0, PC frozen at 0x00400008. Then inst_ready=1 → entries drain in order with no duplicates or loss.
- redirect with target 0x00400040 while FIFO full and pending → next edge inst_valid=0. The first instruction after that has inst_pc=0x00400040, and pre-redirect PCs are never presented.
- rst asserted mid-stream for half a cycle → inst_valid drops at once and the fetch restarts at 0x00400000.
- pc_in=0x00402000 with ADDR_W=11 → imem_addr=0x000 (wrap).
- With IFETCH_ALIGN_CHECK_EN, pc_in=0x00400006 → fetch_misalign=1 and imem_req=0. A later redirect clears the flag.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: issues imem reads from pc_in and buffers {inst, pc} in a small FIFO toward decode.
// Optional macro IFETCH_ALIGN_CHECK_EN adds the sticky fetch_misalign output.
module ifetch_unit #(
  parameter int          DEPTH   = 2,
  parameter int          ADDR_W  = 11,
  parameter logic [31:0] BASE_PC = 32'h00400000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc_in,
  output logic              pc_ena,
  input  logic              redirect,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc
`ifdef IFETCH_ALIGN_CHECK_EN
  ,
  output logic              fetch_misalign
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             pending_q, pending_d;
  logic [31:0]      pending_pc_q;
  logic [31:0]      inst_mem_q [DEPTH];
  logic [31:0]      pc_mem_q   [DEPTH];

  logic             pop, push, space, issue_base, issue;
  logic [CNT_W:0]   occupancy;
  logic [31:0]      pc_off;
  logic             unused_pc_bits;

  assign pc_off         = pc_in - BASE_PC;
  assign imem_addr      = pc_off[ADDR_W+1:2];
  assign unused_pc_bits = ^{pc_off[31:ADDR_W+2], pc_off[1:0]};

  assign inst_valid = (count_q != '0);
  assign pop        = inst_valid & inst_ready;
  assign push       = pending_q;

  // The in-flight read already owns a slot, so it counts against capacity.
  assign occupancy  = {1'b0, count_q} + (CNT_W+1)'(pending_q) - (CNT_W+1)'(pop);
  assign space      = occupancy < (CNT_W+1)'(DEPTH);
  assign issue_base = !redirect & space;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic misalign_q;
  logic pc_aligned;

  assign pc_aligned     = (pc_in[1:0] == 2'b00);
  assign issue          = issue_base & !misalign_q & pc_aligned;
  assign fetch_misalign = misalign_q;

  always_ff @(negedge clk or posedge rst) begin
    if (rst)
      misalign_q <= 1'b0;
    else if (redirect)
      misalign_q <= 1'b0;
    else if (issue_base && !pc_aligned)
      misalign_q <= 1'b1;
  end
`else
  assign issue = issue_base;
`endif

  assign imem_req = issue;
  assign pc_ena   = issue | redirect;
  assign inst     = inst_mem_q[rd_ptr_q];
  assign inst_pc  = pc_mem_q[rd_ptr_q];

  always_comb begin
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    pending_d = issue;
    // A flush drops queued entries, the in-flight read and any pop this cycle.
    if (redirect) begin
      count_d   = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      pending_d = 1'b0;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      pending_q    <= 1'b0;
      pending_pc_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      pending_q <= pending_d;
      if (issue)
        pending_pc_q <= pc_in;
      if (push && !redirect) begin
        inst_mem_q[wr_ptr_q] <= imem_rdata;
        pc_mem_q[wr_ptr_q]   <= pending_pc_q;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: bench-side PC register and synchronous imem, plus a
// timestamped fetch-queue reference model (issue at cycle N is deliverable from cycle N+2).
module tb_ifetch_unit;
  localparam int          DEPTH  = 2;
  localparam int          ADDR_W = 11;
  localparam logic [31:0] BASE   = 32'h00400000;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              redirect = 1'b0;
  logic              inst_ready = 1'b0;
  logic [31:0]       target = '0;
  logic [31:0]       pc_reg;
  logic [31:0]       imem_rdata = '0;
  logic              pc_ena, imem_req, inst_valid;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       inst, inst_pc;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic              fetch_misalign;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int          issue_cyc_q[$];
  logic [31:0] issue_pc_q[$];
  logic [31:0] fetch_pc_exp;

  ifetch_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_PC(BASE)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_reg), .pc_ena(pc_ena), .redirect(redirect),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
`ifdef IFETCH_ALIGN_CHECK_EN
    , .fetch_misalign(fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [ADDR_W-1:0] a);
    return 32'h1000 + 32'(a);
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input logic [31:0] pc);
    logic [31:0] off;
    off = (pc - BASE) >> 2;
    return off[ADDR_W-1:0];
  endfunction

  // PC register and instruction memory share the falling edge with the DUT.
  always @(negedge clk or posedge rst)
    if (rst) pc_reg <= BASE;
    else if (pc_ena) pc_reg <= redirect ? target : pc_reg + 32'd4;

  always @(negedge clk)
    if (imem_req) imem_rdata <= memf(imem_addr);

  task automatic model_reset();
    issue_cyc_q.delete();
    issue_pc_q.delete();
    fetch_pc_exp = BASE;
  endtask

  // One cycle: drive at negedge+1, check at posedge, advance the model, return at negedge+1.
  task automatic step(input logic redir, input logic [31:0] tgt, input logic rdy);
    logic exp_valid, exp_issue, pop;
    int   occ;
    redirect = redir; target = tgt; inst_ready = rdy;
    @(posedge clk);
    exp_valid = (issue_pc_q.size() > 0) && (issue_cyc_q[0] <= cyc - 2);
    pop       = exp_valid & rdy;
    occ       = issue_pc_q.size() - (pop ? 1 : 0);
    exp_issue = !redir && (occ < DEPTH);
    checks++;
    if (inst_valid !== exp_valid) begin
      failures++; $display("FAIL inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid, exp_valid);
    end
    checks++;
    if (imem_req !== exp_issue) begin
      failures++; $display("FAIL imem_req cyc=%0d got=%b exp=%b", cyc, imem_req, exp_issue);
    end
    checks++;
    if (pc_ena !== (exp_issue | redir)) begin
      failures++; $display("FAIL pc_ena cyc=%0d got=%b exp=%b", cyc, pc_ena, exp_issue | redir);
    end
    if (exp_issue) begin
      checks++;
      if (pc_reg !== fetch_pc_exp) begin
        failures++; $display("FAIL pc_in cyc=%0d got=%h exp=%h", cyc, pc_reg, fetch_pc_exp);
      end
      checks++;
      if (imem_addr !== addr_of(fetch_pc_exp)) begin
        failures++; $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, addr_of(fetch_pc_exp));
      end
    end
    if (exp_valid) begin
      checks++;
      if (inst_pc !== issue_pc_q[0]) begin
        failures++; $display("FAIL inst_pc cyc=%0d got=%h exp=%h", cyc, inst_pc, issue_pc_q[0]);
      end
      checks++;
      if (inst !== memf(addr_of(issue_pc_q[0]))) begin
        failures++; $display("FAIL inst cyc=%0d got=%h exp=%h", cyc, inst, memf(addr_of(issue_pc_q[0])));
      end
    end
`ifdef IFETCH_ALIGN_CHECK_EN
    if (!redir) begin
      checks++;
      if (fetch_misalign !== 1'b0) begin
        failures++; $display("FAIL misalign_idle cyc=%0d got=%b exp=0", cyc, fetch_misalign);
      end
    end
`endif
    if (pop && !redir) $display("pop cyc=%0d pc=%h inst=%h", cyc, inst_pc, inst);
    if (redir) begin
      issue_cyc_q.delete();
      issue_pc_q.delete();
      fetch_pc_exp = tgt;
    end else begin
      if (pop) begin
        void'(issue_cyc_q.pop_front());
        void'(issue_pc_q.pop_front());
      end
      if (exp_issue) begin
        issue_cyc_q.push_back(cyc);
        issue_pc_q.push_back(fetch_pc_exp);
        fetch_pc_exp = fetch_pc_exp + 32'd4;
      end
    end
    @(negedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    redirect = 1'b0; inst_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    @(posedge clk);
    checks++;
    if (inst_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", inst_valid); end
    checks++;
    if (inst !== 32'h0) begin failures++; $display("FAIL rst_inst got=%h exp=0", inst); end
    checks++;
    if (inst_pc !== 32'h0) begin failures++; $display("FAIL rst_inst_pc got=%h exp=0", inst_pc); end
    checks++;
    if (imem_req !== 1'b1) begin failures++; $display("FAIL rst_imem_req got=%b exp=1", imem_req); end
    checks++;
    if (pc_ena !== 1'b1) begin failures++; $display("FAIL rst_pc_ena got=%b exp=1", pc_ena); end
    checks++;
    if (imem_addr !== '0) begin failures++; $display("FAIL rst_imem_addr got=%h exp=0", imem_addr); end
`ifdef IFETCH_ALIGN_CHECK_EN
    checks++;
    if (fetch_misalign !== 1'b0) begin failures++; $display("FAIL rst_misalign got=%b exp=0", fetch_misalign); end
`endif
    @(negedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_stream();
    repeat (12) step(1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_stall();
    do_reset();
    repeat (5) step(1'b0, 32'h0, 1'b0);
    #1;
    checks++;
    if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_imem_req got=%b exp=0", imem_req); end
    checks++;
    if (pc_ena !== 1'b0) begin failures++; $display("FAIL stall_pc_ena got=%b exp=0", pc_ena); end
    checks++;
    if (pc_reg !== BASE + 32'd8) begin failures++; $display("FAIL stall_pc got=%h exp=%h", pc_reg, BASE + 32'd8); end
    checks++;
    if (inst_valid !== 1'b1) begin failures++; $display("FAIL stall_valid got=%b exp=1", inst_valid); end
    repeat (8) step(1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (2) step(1'b0, 32'h0, 1'b0);
    step(1'b1, BASE + 32'h40, 1'b1);
    checks++;
    if (inst_valid !== 1'b0) begin failures++; $display("FAIL redirect_flush got=%b exp=0", inst_valid); end
    repeat (8) step(1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_wrap();
    step(1'b1, 32'h00402000, 1'b1);
    redirect = 1'b0;
    #1;
    checks++;
    if (imem_addr !== '0) begin failures++; $display("FAIL wrap_addr got=%h exp=0", imem_addr); end
    checks++;
    if (imem_req !== 1'b1) begin failures++; $display("FAIL wrap_req got=%b exp=1", imem_req); end
    repeat (5) step(1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_async_reset();
    repeat (6) step(1'b0, 32'h0, 1'b1);
    redirect = 1'b0; inst_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (inst_valid !== 1'b0) begin failures++; $display("FAIL async_rst_valid got=%b exp=0", inst_valid); end
    checks++;
    if (inst_pc !== 32'h0) begin failures++; $display("FAIL async_rst_inst_pc got=%h exp=0", inst_pc); end
    @(negedge clk); #1;
    rst = 1'b0;
    model_reset();
    cyc++;
    checks++;
    if (pc_reg !== BASE) begin failures++; $display("FAIL async_rst_pc got=%h exp=%h", pc_reg, BASE); end
    repeat (8) step(1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_random();
    logic        r_redir, r_rdy;
    logic [31:0] r_tgt;
    for (int i = 0; i < 400; i++) begin
      r_redir = ($urandom_range(0, 15) == 0);
      r_rdy   = ($urandom_range(0, 3) != 0);
      r_tgt   = BASE + 32'($urandom_range(0, 4095)) * 32'd4;
      step(r_redir, r_tgt, r_rdy);
    end
  endtask

`ifdef IFETCH_ALIGN_CHECK_EN
  task automatic test_misalign();
    step(1'b1, 32'h00400006, 1'b1);
    redirect = 1'b0; inst_ready = 1'b1;
    @(posedge clk);
    checks++;
    if (imem_req !== 1'b0) begin failures++; $display("FAIL misalign_req got=%b exp=0", imem_req); end
    checks++;
    if (pc_ena !== 1'b0) begin failures++; $display("FAIL misalign_pc_ena got=%b exp=0", pc_ena); end
    @(negedge clk); #1;
    cyc++;
    checks++;
    if (fetch_misalign !== 1'b1) begin failures++; $display("FAIL misalign_set got=%b exp=1", fetch_misalign); end
    checks++;
    if (imem_req !== 1'b0) begin failures++; $display("FAIL misalign_hold_req got=%b exp=0", imem_req); end
    step(1'b1, BASE, 1'b1);
    checks++;
    if (fetch_misalign !== 1'b0) begin failures++; $display("FAIL misalign_clear got=%b exp=0", fetch_misalign); end
    repeat (6) step(1'b0, 32'h0, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_async_reset();
`ifdef IFETCH_ALIGN_CHECK_EN
    test_misalign();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
